pipe_tail_fifo: RTL and testbench

PIPE_TAIL_FIFO -- requirements
Module: pipe_tail_fifo

---
 rtl/pipe_tail_fifo.sv | 78 +++++++
 tb/tb_pipe_tail_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_tail_fifo.sv
// Tail stage of a pipe-register chain: a DEPTH-entry FIFO that accepts the
// upstream stage's word whenever low_empty is high and presents it to a consumer.
module pipe_tail_fifo #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [DSIZE-1:0] up_data,
    output logic             low_empty,
    input  logic             flush,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             out_ready,
    output logic [AW:0]      level,
    output logic             full
);

    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

    logic [DSIZE-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      level_reg, level_next;
    logic             push, pop;

    // Acceptance depends only on registered level and flush, so the upstream
    // stage never sees a combinational path from its own valid or from out_ready.
    assign full      = (level_reg == LEVEL_MAX);
    assign low_empty = !full && !flush;
    assign out_valid = (level_reg != '0);
    assign out_data  = mem_reg[rd_ptr_reg];
    assign level     = level_reg;

    assign push = up_valid && low_empty;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push)
                wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_next = rd_ptr_reg + 1'b1;
            if (push && !pop)
                level_next = level_reg + 1'b1;
            else if (pop && !push)
                level_next = level_reg - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage is left unreset; out_valid masks stale contents.
    always_ff @(posedge clock) begin
        if (push)
            mem_reg[wr_ptr_reg] <= up_data;
    end

endmodule

// File: tb/tb_pipe_tail_fifo.sv
// Directed bench for pipe_tail_fifo: vector table plus streaming and reset-pulse sequences.
module tb_pipe_tail_fifo;

    logic       clock;
    logic       rst_n;
    logic       up_valid;
    logic [7:0] up_data;
    logic       low_empty;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] level;
    logic       full;

    int checks = 0;
    int errors = 0;

    pipe_tail_fifo #(.DSIZE(8), .DEPTH(4), .AW(2)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .up_valid  (up_valid),
        .up_data   (up_data),
        .low_empty (low_empty),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .full      (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       uv;
        logic [7:0] d;
        logic       fl;
        logic       ordy;
        logic       le;
        logic       ov;
        logic       chkd;
        logic [7:0] od;
        logic [2:0] lvl;
        logic       fu;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //          uv  d      fl ordy le ov chkd od     lvl fu
        vecs[0]  = '{1, 8'h11, 0, 0,   1, 0, 0,   8'h00, 0, 0};
        vecs[1]  = '{1, 8'h22, 0, 0,   1, 1, 1,   8'h11, 1, 0};
        vecs[2]  = '{1, 8'h33, 0, 0,   1, 1, 1,   8'h11, 2, 0};
        vecs[3]  = '{0, 8'h00, 0, 0,   1, 1, 1,   8'h11, 3, 0};
        vecs[4]  = '{1, 8'h44, 0, 0,   1, 1, 1,   8'h11, 3, 0};
        vecs[5]  = '{1, 8'h55, 0, 0,   0, 1, 1,   8'h11, 4, 1};
        vecs[6]  = '{1, 8'h55, 0, 1,   0, 1, 1,   8'h11, 4, 1};
        vecs[7]  = '{1, 8'h55, 0, 0,   1, 1, 1,   8'h22, 3, 0};
        vecs[8]  = '{0, 8'h00, 0, 1,   0, 1, 1,   8'h22, 4, 1};
        vecs[9]  = '{0, 8'h00, 0, 1,   1, 1, 1,   8'h33, 3, 0};
        vecs[10] = '{0, 8'h00, 0, 1,   1, 1, 1,   8'h44, 2, 0};
        vecs[11] = '{0, 8'h00, 0, 1,   1, 1, 1,   8'h55, 1, 0};
        vecs[12] = '{0, 8'h00, 0, 0,   1, 0, 0,   8'h00, 0, 0};
        vecs[13] = '{1, 8'h66, 0, 0,   1, 0, 0,   8'h00, 0, 0};
        vecs[14] = '{1, 8'h77, 0, 0,   1, 1, 1,   8'h66, 1, 0};
        vecs[15] = '{1, 8'h88, 0, 0,   1, 1, 1,   8'h66, 2, 0};
        vecs[16] = '{1, 8'h99, 1, 1,   0, 1, 1,   8'h66, 3, 0};
        vecs[17] = '{0, 8'h00, 0, 1,   1, 0, 0,   8'h00, 0, 0};
        vecs[18] = '{1, 8'hAB, 0, 0,   1, 0, 0,   8'h00, 0, 0};
        vecs[19] = '{0, 8'h00, 0, 0,   1, 1, 1,   8'hAB, 1, 0};

        rst_n = 1'b0;
        up_valid = 1'b0;
        up_data = 8'h00;
        flush = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_low_empty", 32'(low_empty), 32'd1);
        $display("reset: level=%0d out_valid=%0b full=%0b low_empty=%0b", level, out_valid, full, low_empty);
        @(posedge clock);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            up_valid  = vecs[i].uv;
            up_data   = vecs[i].d;
            flush     = vecs[i].fl;
            out_ready = vecs[i].ordy;
            @(negedge clock);
            $display("vec %0d: uv=%0b d=%0h fl=%0b rdy=%0b -> le=%0b ov=%0b od=%0h lvl=%0d full=%0b",
                     i, up_valid, up_data, flush, out_ready, low_empty, out_valid, out_data, level, full);
            chk($sformatf("vec%0d_low_empty", i), 32'(low_empty), 32'(vecs[i].le));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].fu));
            if (vecs[i].chkd)
                chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
            @(posedge clock);
            #1;
        end

        // Drain the leftover 0xAB so the stream starts empty.
        up_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;

        // Streaming: push and pop every cycle; head lags input by one word.
        for (int k = 0; k <= 20; k++) begin
            up_valid  = (k < 20);
            up_data   = 8'(k);
            out_ready = 1'b1;
            @(negedge clock);
            $display("stream %0d: d=%0h -> ov=%0b od=%0h lvl=%0d", k, up_data, out_valid, out_data, level);
            if (k == 0) begin
                chk("stream0_out_valid", 32'(out_valid), 32'd0);
                chk("stream0_level", 32'(level), 32'd0);
            end else begin
                chk($sformatf("stream%0d_out_valid", k), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d_out_data", k), 32'(out_data), 32'(k - 1));
                chk($sformatf("stream%0d_level", k), 32'(level), 32'd1);
            end
            @(posedge clock);
            #1;
        end
        up_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        chk("stream_drained_level", 32'(level), 32'd0);
        @(posedge clock);
        #1;

        // Async reset pulse between edges at level 2.
        up_valid = 1'b1;
        up_data = 8'hC1;
        @(posedge clock);
        #1;
        up_data = 8'hC2;
        @(posedge clock);
        #1;
        up_valid = 1'b0;
        chk("prepulse_level", 32'(level), 32'd2);
        rst_n = 1'b0;
        #1;
        $display("reset pulse: level=%0d out_valid=%0b low_empty=%0b", level, out_valid, low_empty);
        chk("pulse_out_valid", 32'(out_valid), 32'd0);
        chk("pulse_level", 32'(level), 32'd0);
        chk("pulse_low_empty", 32'(low_empty), 32'd1);
        #1;
        rst_n = 1'b1;
        up_valid = 1'b1;
        up_data = 8'hA5;
        @(negedge clock);
        chk("postpulse_out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        up_valid = 1'b0;
        @(negedge clock);
        $display("after pulse push A5: ov=%0b od=%0h lvl=%0d", out_valid, out_data, level);
        chk("postpulse_head_valid", 32'(out_valid), 32'd1);
        chk("postpulse_head_data", 32'(out_data), 32'hA5);
        chk("postpulse_level", 32'(level), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
